payload_tx_gearbox: RTL and testbench

Downstream of the order payload builder: consumes its 256-bit order-message beats (tvalid/tready/tlast), trims each message to its declared byte length, and re-emits it as a 64-bit byte-qualified stream toward the MAC/TCP transmit path. Appends a one-byte checksum (sum of all message bytes mod 256) directly after the last message byte. It is the only place message length and checksum are enforced before the wire.

---
 rtl/payload_tx_gearbox_pkg.sv | 11 +
 rtl/payload_tx_gearbox_if.sv | 24 ++
 rtl/payload_tx_gearbox_csum_adder.sv | 15 +
 rtl/payload_tx_gearbox.sv | 106 ++++++++++
 tb/tb_payload_tx_gearbox.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/payload_tx_gearbox_pkg.sv
// payload_tx_gearbox_pkg: shared widths, lane counts, FSM states and byte-lane helper
package payload_tx_gearbox_pkg;
   localparam int DATA_IN_W  = 256;
   localparam int DATA_OUT_W = 64;
   localparam int IN_LANES   = 32;
   localparam int OUT_LANES  = 8;
   typedef enum logic [1:0] {IDLE, DRAIN, CSUM, DISCARD} state_t;
   function automatic logic [7:0] lane_byte(input logic [DATA_OUT_W-1:0] w, input int j);
      return w[DATA_OUT_W-1-8*j -: 8];
   endfunction
endpackage

// File: rtl/payload_tx_gearbox_if.sv
// payload_tx_gearbox_if: upstream beat stream, downstream word stream and status of the gearbox
interface payload_tx_gearbox_if;
   import payload_tx_gearbox_pkg::*;
   logic [DATA_IN_W-1:0]  s_tdata;
   logic                  s_tvalid;
   logic                  s_tlast;
   logic                  s_tready;
   logic [7:0]            msg_len;
   logic [DATA_OUT_W-1:0] m_tdata;
   logic [7:0]            m_tkeep;
   logic                  m_tvalid;
   logic                  m_tlast;
   logic                  m_tready;
   logic                  err_short;
   logic                  busy;
   modport slave (
      input  s_tdata, s_tvalid, s_tlast, msg_len, m_tready,
      output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast, err_short, busy
   );
   modport master (
      output s_tdata, s_tvalid, s_tlast, msg_len, m_tready,
      input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast, err_short, busy
   );
endinterface

// File: rtl/payload_tx_gearbox_csum_adder.sv
// payload_tx_gearbox_csum_adder: adds the kept byte lanes of a word onto an 8-bit running sum
module payload_tx_gearbox_csum_adder
   import payload_tx_gearbox_pkg::*;
(
   input  logic [DATA_OUT_W-1:0] data,
   input  logic [7:0]            keep,
   input  logic [7:0]            acc,
   output logic [7:0]            sum
);
   always_comb begin
      sum = acc;
      for (int j = 0; j < OUT_LANES; j++)
         if (keep[j]) sum = sum + lane_byte(data, j);
   end
endmodule

// File: rtl/payload_tx_gearbox.sv
// payload_tx_gearbox: trims 256-bit order beats to msg_len bytes and re-emits them as
// 64-bit byte-qualified words followed by a one-byte mod-256 checksum
module payload_tx_gearbox
   import payload_tx_gearbox_pkg::*;
(
   input  logic               clk,
   input  logic               resetn,
   payload_tx_gearbox_if.slave bus
);
   state_t                state, state_nx;
   logic [DATA_IN_W-1:0]  hold;
   logic [1:0]            wi;
   logic [7:0]            rem, sum, word_sum, keep_d;
   logic [3:0]            n;
   logic [DATA_OUT_W-1:0] word, word_m;
   logic                  full, seen_last, short_msg;
   logic                  last_word, end_msg, drain_fire, load;
   assign word       = hold[DATA_IN_W-1-DATA_OUT_W*int'(wi) -: DATA_OUT_W];
   assign n          = rem >= 8'd8 ? 4'd8 : rem[3:0];
   assign keep_d     = 8'((9'd1 << n) - 9'd1);
   assign end_msg    = rem == {4'd0, n};
   assign last_word  = wi == 2'(IN_LANES / OUT_LANES - 1);
   assign drain_fire = state == DRAIN && full && bus.m_tready;
   assign load       = bus.s_tvalid && bus.s_tready && state != DISCARD;
   assign bus.busy   = state != IDLE;
   payload_tx_gearbox_csum_adder u_csum (.data(word), .keep(keep_d), .acc(sum), .sum(word_sum));
   always_comb begin
      for (int j = 0; j < OUT_LANES; j++)
         word_m[DATA_OUT_W-1-8*j -: 8] = keep_d[j] ? lane_byte(word, j) : 8'd0;
   end
   always_comb begin
      state_nx      = state;
      bus.s_tready  = 1'b0;
      bus.m_tvalid  = 1'b0;
      bus.m_tdata   = '0;
      bus.m_tkeep   = '0;
      bus.m_tlast   = 1'b0;
      bus.err_short = 1'b0;
      case (state)
         IDLE: begin
            bus.s_tready = resetn;
            if (bus.s_tvalid && resetn) state_nx = bus.msg_len == 8'd0 ? CSUM : DRAIN;
         end
         DRAIN: begin
            bus.m_tvalid = full;
            bus.m_tdata  = word_m;
            bus.m_tkeep  = keep_d;
            // a short final word has room for the checksum right after the data
            if (end_msg && n != 4'd8) begin
               bus.m_tdata = word_m | ({word_sum, 56'd0} >> {n, 3'd0});
               bus.m_tkeep = {keep_d[6:0], 1'b1};
               bus.m_tlast = 1'b1;
            end
            bus.s_tready = !full || (drain_fire && last_word && !end_msg && !seen_last);
            if (drain_fire && end_msg) state_nx = n != 4'd8 ? (seen_last ? IDLE : DISCARD) : CSUM;
            else if (drain_fire && last_word && seen_last) state_nx = CSUM;
         end
         CSUM: begin
            bus.m_tvalid  = 1'b1;
            bus.m_tdata   = {sum, 56'd0};
            bus.m_tkeep   = 8'h01;
            bus.m_tlast   = 1'b1;
            bus.err_short = short_msg && bus.m_tready;
            if (bus.m_tready) state_nx = seen_last ? IDLE : DISCARD;
         end
         DISCARD: begin
            bus.s_tready = 1'b1;
            if (bus.s_tvalid && bus.s_tlast) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         hold      <= '0;
         wi        <= '0;
         rem       <= '0;
         sum       <= '0;
         full      <= 1'b0;
         seen_last <= 1'b0;
         short_msg <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && bus.s_tvalid) begin
            rem       <= bus.msg_len;
            sum       <= '0;
            short_msg <= 1'b0;
         end
         if (drain_fire) begin
            rem <= rem - {4'd0, n};
            sum <= word_sum;
            wi  <= wi + 2'd1;
            if (last_word) full <= 1'b0;
            if (last_word && !end_msg && seen_last) short_msg <= 1'b1;
         end
         // a refill beat overrides the pointer advance of the word leaving this cycle
         if (load) begin
            hold      <= bus.s_tdata;
            wi        <= '0;
            full      <= 1'b1;
            seen_last <= bus.s_tlast;
         end
      end
   end
endmodule

// File: tb/tb_payload_tx_gearbox.sv
// tb_payload_tx_gearbox: scoreboard bench; expected words come from a byte-list model of each message
module tb_payload_tx_gearbox;
   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        err;
   } word_t;
   logic       clk, resetn;
   int         checks = 0, failures = 0, words_seen = 0, mode = 0;
   logic [7:0] msg_bytes[$];
   word_t      exp_q[$];
   payload_tx_gearbox_if bus();
   payload_tx_gearbox dut (.clk(clk), .resetn(resetn), .bus(bus));
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   // model: kept bytes then the checksum byte, packed 8 per word from lane 0
   task automatic push_expected(input int len);
      logic [7:0] out[$];
      logic [7:0] cs;
      word_t      e;
      int         take;
      cs = 0;
      take = len < msg_bytes.size() ? len : msg_bytes.size();
      for (int i = 0; i < take; i++) begin
         out.push_back(msg_bytes[i]);
         cs = cs + msg_bytes[i];
      end
      out.push_back(cs);
      for (int w = 0; w * 8 < out.size(); w++) begin
         e = '0;
         for (int j = 0; j < 8 && w * 8 + j < out.size(); j++) begin
            e.data[63-8*j -: 8] = out[w*8+j];
            e.keep[j] = 1'b1;
         end
         e.last = (w + 1) * 8 >= out.size();
         e.err  = e.last && take < len;
         exp_q.push_back(e);
      end
   endtask
   task automatic drive_beat(input int b, input logic last, input logic [7:0] len);
      logic [255:0] d;
      logic         acc;
      int           cnt;
      for (int k = 0; k < 32; k++) d[255-8*k -: 8] = msg_bytes[b*32+k];
      bus.s_tdata  = d;
      bus.s_tlast  = last;
      bus.msg_len  = len;
      bus.s_tvalid = 1'b1;
      acc = 1'b0;
      cnt = 0;
      while (!acc && cnt < 500) begin
         @(negedge clk);
         acc = bus.s_tready;
         @(posedge clk);
         #1;
         cnt++;
      end
      if (!acc) begin
         checks++;
         failures++;
         $display("FAIL beat_accept_timeout: got s_tready=0 for %0d cycles expected 1", cnt);
      end
   endtask
   task automatic send_msg(input int len, input int nbeats, input bit rnd);
      msg_bytes.delete();
      for (int i = 0; i < nbeats * 32; i++) msg_bytes.push_back(rnd ? 8'($urandom) : 8'(i));
      push_expected(len);
      for (int b = 0; b < nbeats; b++) begin
         if (rnd && $urandom_range(0, 3) == 0) begin
            bus.s_tvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         drive_beat(b, b == nbeats - 1, 8'(len));
      end
      bus.s_tvalid = 1'b0;
   endtask
   task automatic wait_drain();
      int cnt;
      cnt = 0;
      while ((exp_q.size() != 0 || bus.busy) && cnt < 3000) begin
         @(negedge clk);
         cnt++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask
   task automatic check_reset_outputs();
      chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
      chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
      chk("rst_m_tlast", 64'(bus.m_tlast), 64'd0);
      chk("rst_m_tkeep", 64'(bus.m_tkeep), 64'd0);
      chk("rst_m_tdata", bus.m_tdata, 64'd0);
      chk("rst_err_short", 64'(bus.err_short), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
   endtask
   initial begin
      bus.m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.m_tready = mode == 0 ? 1'b1 : mode == 1 ? !bus.m_tready : ($urandom_range(0, 3) != 0);
      end
   end
   // monitor: pops the scoreboard on every accepted word and watches handshake rules
   initial begin
      logic        stalled, after_last, expect_valid;
      logic [63:0] sd;
      logic [7:0]  sk;
      logic        sl;
      word_t       e;
      stalled = 0;
      after_last = 0;
      expect_valid = 0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            stalled = 0;
            after_last = 0;
            expect_valid = 0;
         end else begin
            if (stalled) begin
               chk("stall_valid", 64'(bus.m_tvalid), 64'd1);
               chk("stall_data", bus.m_tdata, sd);
               chk("stall_keep", 64'(bus.m_tkeep), 64'(sk));
               chk("stall_last", 64'(bus.m_tlast), 64'(sl));
            end
            if (expect_valid) chk("first_word_latency", 64'(bus.m_tvalid), 64'd1);
            if (after_last) chk("ready_after_last", 64'(bus.s_tready), 64'd1);
            expect_valid = bus.s_tvalid && bus.s_tready && !bus.busy;
            after_last   = bus.m_tvalid && bus.m_tready && bus.m_tlast;
            stalled      = bus.m_tvalid && !bus.m_tready;
            if (stalled) begin
               sd = bus.m_tdata;
               sk = bus.m_tkeep;
               sl = bus.m_tlast;
               chk("no_refill_while_stalled", 64'(bus.s_tready), 64'd0);
            end
            if (bus.m_tvalid && bus.m_tready) begin
               words_seen++;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL extra_word: got %h with none expected", bus.m_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("word_data", bus.m_tdata, e.data);
                  chk("word_keep", 64'(bus.m_tkeep), 64'(e.keep));
                  chk("word_last", 64'(bus.m_tlast), 64'(e.last));
                  chk("word_err_short", 64'(bus.err_short), 64'(e.err));
               end
            end else chk("err_short_quiet", 64'(bus.err_short), 64'd0);
         end
      end
   end
   initial begin
      int base;
      resetn = 1'b0;
      bus.s_tvalid = 1'b0;
      bus.s_tdata = '0;
      bus.s_tlast = 1'b0;
      bus.msg_len = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1 resetn = 1'b1;
      send_msg(40, 2, 0);
      wait_drain();
      send_msg(45, 2, 0);
      wait_drain();
      mode = 1;
      send_msg(45, 2, 0);
      wait_drain();
      mode = 0;
      send_msg(100, 1, 0);
      wait_drain();
      send_msg(32, 1, 0);
      send_msg(32, 1, 0);
      wait_drain();
      send_msg(0, 2, 0);
      wait_drain();
      msg_bytes.delete();
      for (int i = 0; i < 64; i++) msg_bytes.push_back(8'(i));
      push_expected(45);
      base = words_seen;
      drive_beat(0, 1'b0, 8'd45);
      bus.s_tvalid = 1'b0;
      for (int i = 0; i < 50 && words_seen < base + 2; i++) @(negedge clk);
      chk("third_word_reached", 64'(words_seen >= base + 2), 64'd1);
      @(posedge clk);
      #1 resetn = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk);
      #1 resetn = 1'b1;
      send_msg(8, 1, 0);
      wait_drain();
      mode = 2;
      repeat (30) send_msg($urandom_range(0, 140), $urandom_range(1, 5), 1);
      wait_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
